// File: rtl/sv_cosim_capture.sv
// -----------------------------------------------------------------------------
// sv_cosim_capture
//
// Purpose:
//   Captures 128-bit result vectors from the gate-under-test stage into a
//   small FIFO. Each vector is replayed downstream as four 32-bit beats, most
//   significant word first. An optional running signature folds every
//   accepted vector into a 128-bit rotate-XOR accumulator.
//
// Configuration:
//   SV_COSIM_CAPTURE_SIG_EN - when defined, builds the signature register and
//                             the sig output port. When undefined, neither
//                             exists. All other behaviour is the same.
//
// Parameters:
//   DEPTH     - number of 128-bit vectors buffered (power of two, 2..16).
//
// Ports:
//   clk       - single clock; all state changes on its rising edge.
//   rst       - synchronous, active-high reset.
//   in_valid  - upstream vector present.
//   in_ready  - vector accepted when high together with in_valid.
//   in_data   - 128-bit vector, packed MSB-first.
//   out_valid - a serialized beat is present.
//   out_ready - downstream consumes the current beat.
//   out_data  - current 32-bit beat.
//   out_last  - marks the fourth (final) beat of a vector.
//   count     - FIFO occupancy in vectors.
//   sig       - running signature (only with SV_COSIM_CAPTURE_SIG_EN).
// -----------------------------------------------------------------------------
module sv_cosim_capture #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [127:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count
`ifdef SV_COSIM_CAPTURE_SIG_EN
  ,
  output logic [127:0]             sig
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [127:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [1:0]    r_beat;

  logic          w_full;
  logic          w_push;
  logic          w_beat_xfer;
  logic          w_pop;
  logic [127:0]  w_head;

  // Readiness depends only on registered occupancy, so a pop in the same
  // cycle never opens a full FIFO. During reset, the input is reported ready
  // and the output is reported idle, whatever the stale occupancy is.
  assign w_full      = (r_count == (PW+1)'(DEPTH));
  assign in_ready    = rst | ~w_full;
  assign out_valid   = ~rst & (r_count != '0);
  assign w_push      = in_valid & in_ready & ~rst;
  assign w_beat_xfer = out_valid & out_ready;
  assign w_pop       = w_beat_xfer & (r_beat == 2'd3);
  assign out_last    = out_valid & (r_beat == 2'd3);
  assign count       = r_count;
  assign w_head      = r_mem[r_rd_ptr];

  // Beat 0 carries bits 127:96. Idle output is forced to zero.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    out_data = '0;
    if (out_valid) begin
      unique case (r_beat)
        2'd0: out_data = w_head[127:96];
        2'd1: out_data = w_head[95:64];
        2'd2: out_data = w_head[63:32];
        2'd3: out_data = w_head[31:0];
      endcase
    end
  end

  // NOTE: the vector storage has no reset. Occupancy and pointers decide which entries are live, so reset stays off the wide data path.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_beat   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      // The 2-bit beat index wraps from 3 back to 0 on the popping transfer.
      if (w_beat_xfer) begin
        r_beat <= r_beat + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SV_COSIM_CAPTURE_SIG_EN
  logic [127:0] r_sig;

  // Rotate left by one, then fold in each accepted vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= '0;
    end else if (w_push) begin
      r_sig <= {r_sig[126:0], r_sig[127]} ^ in_data;
    end
  end

  assign sig = r_sig;
`endif

endmodule

// File: tb/tb_sv_cosim_capture.sv
// -----------------------------------------------------------------------------
// tb_sv_cosim_capture
//
// Self-checking bench for sv_cosim_capture (DEPTH = 4). A queue-based
// reference model predicts ready/valid, beat data, last, occupancy and, when
// SV_COSIM_CAPTURE_SIG_EN is defined, the signature. Directed sequences are
// followed by randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_sv_cosim_capture;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [127:0]           in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;
  logic                   out_last;
  logic [$clog2(DEPTH):0] count;
`ifdef SV_COSIM_CAPTURE_SIG_EN
  logic [127:0]           sig;
`endif

  sv_cosim_capture #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (count)
`ifdef SV_COSIM_CAPTURE_SIG_EN
    ,
    .sig       (sig)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending vectors, beat position within the head vector,
  // and the signature accumulator.
  logic [127:0] m_q[$];
  int           m_beat  = 0;
  logic [127:0] m_sig   = '0;
  bit           m_known = 1'b0;

  // Values observed in the most recent cycle, used by the directed checks.
  logic         s_ready;
  logic         s_valid;
  logic [31:0]  s_data;
  logic         s_last;
  logic [127:0] s_count;
`ifdef SV_COSIM_CAPTURE_SIG_EN
  logic [127:0] s_sig;
`endif

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle. Inputs are driven after the falling edge, outputs are
  // compared against the model, and then the model takes the rising edge.
  task automatic cycle(input logic r, input logic iv, input logic [127:0] d, input logic ordy);
    logic         exp_ready;
    logic         exp_valid;
    logic [127:0] head;
    logic [31:0]  exp_data;
    logic         exp_last;
    bit           push;
    bit           pop;
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_ready = r || (m_q.size() < DEPTH);
    exp_valid = !r && (m_q.size() != 0);
    head      = exp_valid ? m_q[0] : '0;
    exp_data  = exp_valid ? 32'(head >> (96 - 32 * m_beat)) : 32'h0;
    exp_last  = exp_valid && (m_beat == 3);
    check("in_ready",  128'(in_ready),  128'(exp_ready));
    check("out_valid", 128'(out_valid), 128'(exp_valid));
    check("out_data",  128'(out_data),  128'(exp_data));
    check("out_last",  128'(out_last),  128'(exp_last));
    if (m_known) begin
      check("count", 128'(count), 128'(m_q.size()));
`ifdef SV_COSIM_CAPTURE_SIG_EN
      check("sig", sig, m_sig);
`endif
    end
    s_ready = in_ready;
    s_valid = out_valid;
    s_data  = out_data;
    s_last  = out_last;
    s_count = 128'(count);
`ifdef SV_COSIM_CAPTURE_SIG_EN
    s_sig   = sig;
`endif
    if (r) begin
      m_q.delete();
      m_beat  = 0;
      m_sig   = '0;
      m_known = 1'b1;
    end else begin
      pop  = exp_valid && ordy && (m_beat == 3);
      push = iv && exp_ready;
      if (exp_valid && ordy) m_beat = (m_beat + 1) % 4;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(d);
        m_sig = {m_sig[126:0], m_sig[127]} ^ d;
      end
    end
    @(posedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] vec_a;
  logic [31:0]  beats_exp [4];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    vec_a     = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    beats_exp = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    // Reset state: in_ready high and output idle during reset and after it.
    cycle(1'b1, 1'b1, rnd128(), 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    check("rst_in_ready", 128'(s_ready), 128'(1));
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("post_rst_count", s_count, 128'(0));
    check("post_rst_valid", 128'(s_valid), 128'(0));

    // Single vector, always-ready sink: four beats start the cycle after the push.
    cycle(1'b0, 1'b1, vec_a, 1'b1);
    check("push_cycle_valid", 128'(s_valid), 128'(0));
    for (int b = 0; b < 4; b++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      check("beat_data", 128'(s_data), 128'(beats_exp[b]));
      check("beat_last", 128'(s_last), 128'(b == 3));
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("drained_valid", 128'(s_valid), 128'(0));

    // Fill with a stalled sink: exactly DEPTH accepted, ready drops on the 5th cycle.
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, rnd128(), 1'b0);
      check("fill_in_ready", 128'(s_ready), 128'(i < DEPTH));
    end
    check("fill_count", s_count, 128'(DEPTH));

    // Full FIFO with both sides active: no push on the cycle the last beat pops.
    for (int b = 0; b < 4; b++) begin
      cycle(1'b0, 1'b1, rnd128(), 1'b1);
      check("full_no_push", 128'(s_ready), 128'(0));
    end
    cycle(1'b0, 1'b1, rnd128(), 1'b0);
    check("after_pop_ready", 128'(s_ready), 128'(1));
    check("after_pop_count", s_count, 128'(DEPTH - 1));
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("refill_count", s_count, 128'(DEPTH));

    // Stall mid-vector: out_ready 1,0,0,1 holds the beat across stalled cycles.
    cycle(1'b0, 1'b0, '0, 1'b1);
    begin
      logic [31:0] held;
      cycle(1'b0, 1'b0, '0, 1'b0);
      held = s_data;
      cycle(1'b0, 1'b0, '0, 1'b0);
      check("stall_hold", 128'(s_data), 128'(held));
      cycle(1'b0, 1'b0, '0, 1'b1);
      check("stall_release", 128'(s_data), 128'(held));
    end

    // Reset in the middle of a three-vector backlog, after beat 1 has gone.
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rnd128(), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, rnd128(), 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("mid_rst_valid", 128'(s_valid), 128'(0));
    check("mid_rst_count", s_count, 128'(0));
    check("mid_rst_ready", 128'(s_ready), 128'(1));
    cycle(1'b0, 1'b1, vec_a, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("restart_beat0", 128'(s_data), 128'(beats_exp[0]));

`ifdef SV_COSIM_CAPTURE_SIG_EN
    // Signature: pushing 1 twice gives 1 then 3.
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 128'h1, 1'b0);
    cycle(1'b0, 1'b1, 128'h1, 1'b0);
    check("sig_first", s_sig, 128'h1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("sig_second", s_sig, 128'h3);
`endif

    // Randomized traffic with bursty valid/ready and occasional resets.
    for (int i = 0; i < 800; i++) begin
      logic r;
      logic iv;
      logic ordy;
      r    = ($urandom_range(0, 79) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle(r, iv, rnd128(), ordy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
